// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures memory-stage results, bubbles on cache stall, freezes after HALT.
// Optional performance counters are enabled by defining MEMWB_PERF_EN.
module mem_wb_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] MemOut,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic              Halt,
`ifdef MEMWB_PERF_EN
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_stall,
`endif
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic              wb_en,
    output logic              wb_halt,
    output logic              stall_upstream
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   capture;
    logic   halted;

    assign halted         = (state == HALTED);
    assign stall_upstream = mem_valid & mem_stall & ~halted;
    assign capture        = mem_valid & ~mem_stall & ~halted;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mem_valid && mem_stall)
                    state_nxt = MISS;
                else if (capture && Halt)
                    state_nxt = HALTED;
            end
            MISS: begin
                // A dropped mem_valid mid-miss is treated as a bubble.
                if (!mem_valid)
                    state_nxt = RUN;
                else if (!mem_stall)
                    state_nxt = Halt ? HALTED : RUN;
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_reg   <= '0;
            wb_en    <= 1'b0;
            wb_halt  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                wb_valid <= 1'b1;
                wb_data  <= MemToReg ? MemOut : ALUOut;
                wb_reg   <= WriteReg;
                wb_en    <= RegWrite;
                if (Halt)
                    wb_halt <= 1'b1;
            end else begin
                wb_valid <= 1'b0;
                wb_en    <= 1'b0;
            end
        end
    end

`ifdef MEMWB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (capture && perf_retired != 16'hFFFF)
                perf_retired <= perf_retired + 16'd1;
            if (stall_upstream && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule
